// File: rtl/unified_ram_ctrl.sv
// Unified byte-addressed RAM serving an instruction-fetch port and a data port with 1-cycle responses.
// Optional macro RAM_FETCH_FORWARD_EN forwards same-edge store bytes into the fetch response.
module unified_ram_ctrl #(
  parameter int unsigned MEM_BYTES = 16384,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_valid,
  output logic [31:0]       i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_valid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  input  logic              err_clr,
  output logic              err_sticky,
  output logic [ADDR_W-1:0] err_addr
);

  localparam int unsigned AW = $clog2(MEM_BYTES);
  localparam int unsigned XW = ADDR_W + 1;
  localparam logic [XW-1:0] FETCH_LAST = XW'(MEM_BYTES - 4);
  localparam logic [XW-1:0] MEM_LIMIT  = XW'(MEM_BYTES);

  logic [7:0]    mem [MEM_BYTES];

  logic [AW-1:0] i_idx;
  logic [AW-1:0] d_idx;
  logic          i_fault;
  logic          d_fault;
  logic          d_misalign;
  logic [2:0]    d_bytes;
  logic [XW-1:0] d_end;
  logic          store_ok;
  logic [31:0]   fetch_raw;
  logic [31:0]   fetch_word;
  logic [31:0]   load_raw;
  logic [31:0]   load_ext;
  logic          sign8;
  logic          sign16;

  assign i_idx = i_addr[AW-1:0];
  assign d_idx = d_addr[AW-1:0];

  // Fetch must be word aligned and the whole word inside the array
  assign i_fault = (i_addr[1:0] != 2'b00) || ({1'b0, i_addr} > FETCH_LAST);

  always_comb begin
    d_bytes = 3'd4;
    case (d_size)
      2'b00:   d_bytes = 3'd1;
      2'b01:   d_bytes = 3'd2;
      default: d_bytes = 3'd4;
    endcase
  end

  // Last touched byte computed one bit wider so a huge address cannot wrap into range
  assign d_end      = {1'b0, d_addr} + XW'(d_bytes) - XW'(1);
  assign d_misalign = ((d_size == 2'b01) && d_addr[0]) ||
                      ((d_size == 2'b10) && (d_addr[1:0] != 2'b00));
  assign d_fault    = (d_size == 2'b11) || d_misalign || (d_end >= MEM_LIMIT);
  assign store_ok   = d_req && d_we && !d_fault;

  always_comb begin
    fetch_raw = '0;
    load_raw  = '0;
    for (int k = 0; k < 4; k++) begin
      fetch_raw[8*k +: 8] = mem[i_idx + AW'(k)];
      load_raw[8*k +: 8]  = mem[d_idx + AW'(k)];
    end
  end

`ifdef RAM_FETCH_FORWARD_EN
  logic [AW-1:0] fwd_off;

  // Lanes covered by a store on this edge take the store bytes instead of the array
  always_comb begin
    fetch_word = fetch_raw;
    fwd_off    = '0;
    for (int k = 0; k < 4; k++) begin
      fwd_off = i_idx + AW'(k) - d_idx;
      if (store_ok && (fwd_off < AW'(d_bytes))) begin
        fetch_word[8*k +: 8] = d_wdata[{fwd_off[1:0], 3'b000} +: 8];
      end
    end
  end
`else
  assign fetch_word = fetch_raw;
`endif

  assign sign8  = ~d_unsigned & load_raw[7];
  assign sign16 = ~d_unsigned & load_raw[15];

  always_comb begin
    load_ext = load_raw;
    case (d_size)
      2'b00:   load_ext = {{24{sign8}}, load_raw[7:0]};
      2'b01:   load_ext = {{16{sign16}}, load_raw[15:0]};
      default: load_ext = load_raw;
    endcase
  end

  // Array commit; contents survive reset, writes blocked while reset is asserted
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n && store_ok) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < d_bytes) begin
          mem[d_idx + AW'(k)] <= d_wdata[8*k +: 8];
        end
      end
    end
  end

  // Response registers and sticky error capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_valid    <= 1'b0;
      i_rdata    <= '0;
      i_err      <= 1'b0;
      d_valid    <= 1'b0;
      d_rdata    <= '0;
      d_err      <= 1'b0;
      err_sticky <= 1'b0;
      err_addr   <= '0;
    end else begin
      i_valid <= i_req;
      if (i_req) begin
        i_err   <= i_fault;
        i_rdata <= i_fault ? '0 : fetch_word;
      end
      d_valid <= d_req;
      if (d_req) begin
        d_err   <= d_fault;
        d_rdata <= (d_fault || d_we) ? '0 : load_ext;
      end
      if (d_req && d_fault) begin
        err_sticky <= 1'b1;
        if (!err_sticky || err_clr) err_addr <= d_addr;
      end else if (i_req && i_fault) begin
        err_sticky <= 1'b1;
        if (!err_sticky || err_clr) err_addr <= i_addr;
      end else if (err_clr) begin
        err_sticky <= 1'b0;
        err_addr   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_unified_ram_ctrl.sv
// Randomised and directed bench for unified_ram_ctrl against a byte-array reference model.
// Honours RAM_FETCH_FORWARD_EN the same way as the design.
module tb_unified_ram_ctrl;

  localparam int unsigned MEM = 16384;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_valid, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_unsigned, d_valid, d_err;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        err_clr, err_sticky;
  logic [31:0] err_addr;

  unified_ram_ctrl #(.MEM_BYTES(MEM), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
    .err_clr(err_clr), .err_sticky(err_sticky), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int unsigned vectors;
  int unsigned miscompares;

  logic [7:0]  mm [MEM];
  logic        e_iv, e_ie, e_dv, e_de, m_st;
  logic [31:0] e_ir, e_dr, m_ea;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("i_valid", 32'(i_valid), 32'(e_iv));
    check("i_rdata", i_rdata, e_ir);
    check("i_err", 32'(i_err), 32'(e_ie));
    check("d_valid", 32'(d_valid), 32'(e_dv));
    check("d_rdata", d_rdata, e_dr);
    check("d_err", 32'(d_err), 32'(e_de));
    check("err_sticky", 32'(err_sticky), 32'(m_st));
    check("err_addr", err_addr, m_ea);
  endtask

  task automatic model_reset();
    e_iv = 1'b0; e_ie = 1'b0; e_dv = 1'b0; e_de = 1'b0; m_st = 1'b0;
    e_ir = '0; e_dr = '0; m_ea = '0;
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic bit i_faulty(input logic [31:0] a);
    return ((a % 4) != 0) || (longint'(a) > longint'(MEM) - 4);
  endfunction

  function automatic bit d_faulty(input logic [1:0] sz, input logic [31:0] a);
    int n;
    n = nbytes(sz);
    if (sz == 2'b11) return 1'b1;
    if ((longint'(a) % n) != 0) return 1'b1;
    return (longint'(a) + n - 1) >= longint'(MEM);
  endfunction

  // One clock: drive at negedge, predict from the model, sample 1 ns after the edge
  task automatic cycle(input bit ir, input logic [31:0] ia, input bit dr, input bit dwe,
                       input logic [1:0] ds, input bit du, input logic [31:0] da,
                       input logic [31:0] dw, input bit ec);
    bit          ifl, dfl, st_ok;
    int          n;
    longint      v, ba;
    logic [31:0] fw, sh;
    logic [7:0]  b;
    @(negedge clk);
    i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_size = ds; d_unsigned = du;
    d_addr = da; d_wdata = dw; err_clr = ec;
    ifl = i_faulty(ia);
    dfl = d_faulty(ds, da);
    n = nbytes(ds);
    st_ok = dr && dwe && !dfl;
    e_iv = ir;
    if (ir) begin
      e_ie = ifl;
      fw = '0;
      if (!ifl) begin
        for (int k = 0; k < 4; k++) begin
          ba = longint'(ia) + k;
          b = mm[int'(ba)];
`ifdef RAM_FETCH_FORWARD_EN
          if (st_ok && ba >= longint'(da) && ba < longint'(da) + n) begin
            sh = dw >> (8 * (ba - longint'(da)));
            b = sh[7:0];
          end
`endif
          fw = fw | (32'(b) << (8 * k));
        end
      end
      e_ir = fw;
    end
    e_dv = dr;
    if (dr) begin
      e_de = dfl;
      if (dfl || dwe) e_dr = '0;
      else begin
        v = 0;
        for (int k = 0; k < n; k++) v = v | (longint'(mm[int'(da) + k]) << (8 * k));
        if (!du && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        e_dr = 32'(v);
      end
    end
    if (dr && dfl) begin
      if (!m_st || ec) m_ea = da;
      m_st = 1'b1;
    end else if (ir && ifl) begin
      if (!m_st || ec) m_ea = ia;
      m_st = 1'b1;
    end else if (ec) begin
      m_st = 1'b0;
      m_ea = '0;
    end
    if (st_ok) begin
      for (int k = 0; k < n; k++) begin
        sh = dw >> (8 * k);
        mm[int'(da) + k] = sh[7:0];
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] dw);
    cycle(1'b0, '0, 1'b1, 1'b1, sz, 1'b0, a, dw, 1'b0);
  endtask

  task automatic ld(input logic [1:0] sz, input bit u, input logic [31:0] a);
    cycle(1'b0, '0, 1'b1, 1'b0, sz, u, a, '0, 1'b0);
  endtask

  task automatic idle(input bit ec);
    cycle(1'b0, '0, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0, ec);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: return 32'($urandom_range(0, MEM - 1));
      6, 7:             return 32'(MEM - 8 + $urandom_range(0, 11));
      8:                return 32'($urandom);
      default:          return 32'($urandom_range(0, 63));
    endcase
  endfunction

  initial begin
    logic [31:0] ia, da;
    logic [1:0]  ds;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_size = '0;
    d_unsigned = 1'b0; d_addr = '0; d_wdata = '0; err_clr = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Give every byte a known value
    for (int a = 0; a < int'(MEM); a += 4) st(2'b10, 32'(a), $urandom);

    st(2'b10, 32'h100, 32'hDEADBEEF);
    ld(2'b10, 1'b0, 32'h100);
    check("lw_deadbeef", d_rdata, 32'hDEADBEEF);
    st(2'b00, 32'h203, 32'h80);
    ld(2'b00, 1'b0, 32'h203);
    check("lb_signed", d_rdata, 32'hFFFFFF80);
    ld(2'b00, 1'b1, 32'h203);
    check("lbu", d_rdata, 32'h00000080);
    ld(2'b10, 1'b0, 32'h200);
    check("lw_top_byte", 32'(d_rdata[31:24]), 32'h80);

    ld(2'b01, 1'b0, 32'h101);
    check("lh_misalign_err", 32'(d_err), 32'd1);
    check("lh_misalign_data", d_rdata, 32'd0);
    cycle(1'b1, 32'h4000, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0, 1'b0);
    check("fetch_oor_err", 32'(i_err), 32'd1);
    check("sticky_first", 32'(err_sticky), 32'd1);
    check("sticky_addr_first", err_addr, 32'h101);

    st(2'b10, 32'h3FFC, 32'hA5A55A5A);
    check("sw_top_ok", 32'(d_err), 32'd0);
    st(2'b10, 32'h3FFE, 32'h11111111);
    check("sw_top_err", 32'(d_err), 32'd1);
    st(2'b01, 32'h3FFF, 32'h2222);
    check("sh_top_err", 32'(d_err), 32'd1);
    st(2'b11, 32'h0, 32'h33333333);
    check("size3_err", 32'(d_err), 32'd1);
    ld(2'b10, 1'b0, 32'h3FFC);
    check("top_unchanged", d_rdata, 32'hA5A55A5A);

    idle(1'b1);
    check("clr_sticky", 32'(err_sticky), 32'd0);
    check("clr_addr", err_addr, 32'd0);
    ld(2'b01, 1'b0, 32'h1);
    cycle(1'b1, 32'h6, 1'b1, 1'b0, 2'b10, 1'b0, 32'h22, '0, 1'b1);
    check("clr_with_dual_fault", err_addr, 32'h22);
    idle(1'b1);

    st(2'b10, 32'h40, 32'h00000013);
    cycle(1'b1, 32'h40, 1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678, 1'b0);
`ifdef RAM_FETCH_FORWARD_EN
    check("fetch_vs_store", i_rdata, 32'h12345678);
`else
    check("fetch_vs_store", i_rdata, 32'h00000013);
`endif
    cycle(1'b1, 32'h40, 1'b1, 1'b1, 2'b00, 1'b0, 32'h41, 32'hEE, 1'b0);
`ifdef RAM_FETCH_FORWARD_EN
    check("fetch_vs_store_byte", i_rdata, 32'h1234EE78);
`else
    check("fetch_vs_store_byte", i_rdata, 32'h12345678);
`endif

    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 32'(4 * k), 1'b1, 1'b0, 2'b10, 1'b0, 32'h100, '0, 1'b0);
      check("b2b_fetch_valid", 32'(i_valid), 32'd1);
      check("b2b_load_data", d_rdata, 32'hDEADBEEF);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_i_valid_drop", 32'(i_valid), 32'd0);
    check("rst_d_valid_drop", 32'(d_valid), 32'd0);
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    idle(1'b0);
    check("no_stale_i", 32'(i_valid), 32'd0);
    check("no_stale_d", 32'(d_valid), 32'd0);
    ld(2'b10, 1'b0, 32'h100);
    check("mem_kept_over_reset", d_rdata, 32'hDEADBEEF);

    for (int c = 0; c < 3000; c++) begin
      ds = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 15) == 0) ds = 2'b11;
      da = rand_addr();
      if ($urandom_range(0, 3) != 0) da = da & ~(32'(nbytes(ds)) - 32'd1);
      ia = rand_addr();
      if ($urandom_range(0, 3) != 0) ia[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) ia = da & ~32'd3;
      cycle(1'($urandom_range(0, 1)), ia, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ds, 1'($urandom_range(0, 1)), da, $urandom, ($urandom_range(0, 7) == 0));
    end
    idle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/unified_ram_ctrl.md
Name: unified_ram_ctrl

Overview:
- Parametrised von Neumann memory for the rv32i core, replacing the fixed 16 KB combinational RAM.
- Serves one instruction-fetch port and one data port from a single byte array.
- Both ports use a registered req/valid handshake with one-cycle latency, RISC-V byte/half/word sizing, and misalignment and range error detection.
- A sticky error status register reports the first faulting access.

Parameters:
MEM_BYTES, 16384, array size in bytes; power of two, >= 64
ADDR_W, 32, width of both address ports; the full address is range-checked against MEM_BYTES

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
i_req  input  1  fetch request, sampled at posedge
i_addr  input  ADDR_W  fetch byte address
i_valid  output  1  fetch response strobe, one cycle after i_req
i_rdata  output  32  fetched word, little-endian
i_err  output  1  fetch fault, qualified by i_valid
d_req  input  1  data request
d_we  input  1  1 = store, 0 = load
d_size  input  2  00 byte, 01 half, 10 word, 11 illegal
d_unsigned  input  1  zero-extend loads when 1, sign-extend when 0
d_addr  input  ADDR_W  data byte address
d_wdata  input  32  store data, LSB-aligned: byte in [7:0], half in [15:0]
d_valid  output  1  data response strobe, one cycle after d_req
d_rdata  output  32  load result, extended; 0 for stores and faults
d_err  output  1  data fault, qualified by d_valid
err_clr  input  1  clears the sticky error
err_sticky  output  1  set by any fault
err_addr  output  ADDR_W  address of the first fault since the last clear

Behaviour:
- Reset (rst_n low, asynchronous): i_valid, i_err, d_valid, d_err, err_sticky = 0; i_rdata, d_rdata, err_addr = 0.
- Array contents are not reset.
- Array writes are suppressed while rst_n is low.
- A request in flight when reset asserts is dropped; no response is produced after reset releases.
- Ports are always ready; a new request may be issued every cycle.
- Response timing: request sampled at edge N; valid is high for exactly one cycle after edge N, and rdata/err are valid in that cycle.
- With no request, valid is 0 and rdata/err hold their previous values.
- Fetch fault: i_addr[1:0] != 0, or i_addr > MEM_BYTES-4. On fault, i_rdata = 0.
- Data fault, any one of:
  - d_size = 11;
  - half access with addr[0] = 1;
  - word access with addr[1:0] != 0;
  - addr + access bytes - 1 >= MEM_BYTES.
  - The range check is computed at ADDR_W+1 bits so it cannot wrap.
  - A faulting store writes nothing.
- Store: writes bytes addr .. addr+n-1 from d_wdata low bytes, little-endian, committed at edge N. d_rdata = 0 in the response cycle.
- Load: reads the array as it was before edge N; the bytes are extended per d_unsigned to 32 bits.
- Load and store to the same address cannot occur together (single data port).
- Same-cycle fetch and data store to overlapping bytes: the fetch returns the old bytes, unless the optional feature below is compiled in.
- Sticky error:
  - The first fault sets err_sticky and latches err_addr.
  - Further faults leave err_addr unchanged until err_clr.
  - Both ports faulting in the same cycle: d_addr is latched.
  - err_clr together with a new fault: the new fault wins (sticky set, address latched).
  - err_clr alone clears err_sticky and sets err_addr to 0.

Optional Feature:
- RAM_FETCH_FORWARD_EN defined:
  - A fetch sampled on the same edge as a successful store forwards the stored bytes into i_rdata for every overlapping byte lane.
  - Non-overlapping lanes come from the array.
  - Supports self-modifying code without a stall.
- Not defined: the fetch returns pre-store array contents; no forwarding logic is synthesised.

Test Plan:
- Reset released, then store word 0xDEADBEEF @0x100, then load word @0x100 -> d_valid high one cycle after each request; load d_rdata = 0xDEADBEEF, d_err = 0.
- Store byte 0x80 @0x203, then load byte signed @0x203 -> d_rdata = 0xFFFFFF80; load byte unsigned @0x203 -> d_rdata = 0x00000080; load word @0x200 -> d_rdata[31:24] = 0x80.
- Load half @0x101 -> d_err = 1, d_rdata = 0; then fetch @0x4000 with MEM_BYTES = 16384 -> i_err = 1; err_sticky = 1, err_addr = 0x101.
- Store word @0x3FFC succeeds; store word @0x3FFE faults, array unchanged; store half @0x3FFF faults; d_size = 11 @0x0 faults.
- Same cycle: fetch @0x40 and store word 0x12345678 @0x40, old word 0x00000013 -> i_rdata = 0x00000013 without RAM_FETCH_FORWARD_EN, 0x12345678 with it.
- Back-to-back fetches @0,4,8 with a load @0x100 issued on every cycle -> valid on both ports for three consecutive cycles, data in order; assert rst_n low mid-stream -> all valids drop to 0 immediately, no stale response after release.
